// File: rtl/mem_access_lsu.sv
// MEM-stage load/store unit: one req/ack data-memory transaction per load/store,
// with byte-lane steering on stores and sign/zero extension on loads.
//
// state  | meaning
// IDLE   | waiting for a load/store in EX/MEM; misaligned ops are flagged here
// BUS    | DMEM_REQ held with stable bus outputs until ack or timeout
// DONE   | transaction finished; same instruction still in EX/MEM, never re-issued
module mem_access_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEMREAD_MEM,
    input  logic        MEMWRITE_MEM,
    input  logic [31:0] ALUOUT_MEM,
    input  logic [31:0] PREOP2_MEM,
    input  logic [31:0] INSTR_MEM,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic        STALL_MEM,
    output logic [31:0] LOAD_DATA_MEM,
    output logic        MISALIGN_MEM,
    output logic        BUSERR_MEM
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [31:0] TC_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic        r_misalign, r_buserr;

    logic        w_op, w_aligned, w_issue, w_ack, w_timeout, w_misalign;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shifted, w_load_ext;

    assign w_op   = MEMREAD_MEM | MEMWRITE_MEM;
    assign w_lane = ALUOUT_MEM[1:0];

    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = 32'h0;
        case (INSTR_MEM[13:12])
            2'b00: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << w_lane;
                w_wdata   = {4{PREOP2_MEM[7:0]}};
            end
            2'b01: begin
                w_aligned = ~w_lane[0];
                w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{PREOP2_MEM[15:0]}};
            end
            2'b10: begin
                w_aligned = (w_lane == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = PREOP2_MEM;
            end
            default: begin
                w_aligned = 1'b0;
            end
        endcase
        if (!MEMWRITE_MEM) w_wdata = 32'h0;
    end

    // Halves are only issued with lane[0]==0, so a byte-granular shift serves both sizes.
    assign w_shifted = DMEM_RDATA >> {r_lane, 3'b000};

    always_comb begin
        case (r_f3[1:0])
            2'b00:   w_load_ext = {{24{~r_f3[2] & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_ext = {{16{~r_f3[2] & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = DMEM_RDATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_op && w_aligned) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_BUS;
                end else if (w_op) begin
                    w_misalign  = 1'b1;
                end
            end
            S_BUS: begin
                if (DMEM_ACK) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TC_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign STALL_MEM = ((r_state == S_IDLE) && w_op && w_aligned) || (r_state == S_BUS);

    always_ff @(posedge clk) begin
        if (rst) begin
            DMEM_REQ      <= 1'b0;
            DMEM_WE       <= 1'b0;
            DMEM_ADDR     <= 32'h0;
            DMEM_BE       <= 4'h0;
            DMEM_WDATA    <= 32'h0;
            LOAD_DATA_MEM <= 32'h0;
            r_cnt         <= 32'h0;
            r_lane        <= 2'b00;
            r_f3          <= 3'b000;
            r_misalign    <= 1'b0;
            r_buserr      <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            r_buserr   <= w_timeout;
            if (w_issue) begin
                DMEM_REQ   <= 1'b1;
                DMEM_WE    <= MEMWRITE_MEM;
                DMEM_ADDR  <= {ALUOUT_MEM[31:2], 2'b00};
                DMEM_BE    <= w_be;
                DMEM_WDATA <= w_wdata;
                r_lane     <= w_lane;
                r_f3       <= INSTR_MEM[14:12];
                r_cnt      <= 32'h0;
            end else if (r_state == S_BUS) begin
                if (w_ack || w_timeout) DMEM_REQ <= 1'b0;
                if (w_ack && !DMEM_WE) LOAD_DATA_MEM <= w_load_ext;
                if (!DMEM_ACK) r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign MISALIGN_MEM = r_misalign;
    assign BUSERR_MEM   = r_buserr;

endmodule

// File: tb/tb_mem_access_lsu.sv
// Bench for mem_access_lsu: directed cases plus randomized loads/stores checked
// against a transaction-level model of lane steering, extension and latency.
module tb_mem_access_lsu;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEMREAD_MEM, MEMWRITE_MEM;
    logic [31:0] ALUOUT_MEM, PREOP2_MEM, INSTR_MEM;
    logic        DMEM_REQ, DMEM_WE;
    logic [31:0] DMEM_ADDR;
    logic [3:0]  DMEM_BE;
    logic [31:0] DMEM_WDATA;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;
    logic        STALL_MEM;
    logic [31:0] LOAD_DATA_MEM;
    logic        MISALIGN_MEM, BUSERR_MEM;

    int n_cmp = 0;
    int n_bad = 0;
    bit prev_done = 1'b0;
    logic [31:0] ld_model = 32'h0;

    always #5 clk = ~clk;

    mem_access_lsu #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .MEMREAD_MEM(MEMREAD_MEM), .MEMWRITE_MEM(MEMWRITE_MEM),
        .ALUOUT_MEM(ALUOUT_MEM), .PREOP2_MEM(PREOP2_MEM), .INSTR_MEM(INSTR_MEM),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_BE(DMEM_BE), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .STALL_MEM(STALL_MEM), .LOAD_DATA_MEM(LOAD_DATA_MEM),
        .MISALIGN_MEM(MISALIGN_MEM), .BUSERR_MEM(BUSERR_MEM)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic go_idle(input int n);
        MEMREAD_MEM  = 1'b0;
        MEMWRITE_MEM = 1'b0;
        DMEM_ACK     = 1'b0;
        repeat (n) begin
            @(negedge clk); #1;
        end
        prev_done = 1'b0;
    endtask

    // waits = ack arrives after this many wait cycles; waits >= T means the bus never answers in time.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input int waits);
        int          nb, req_cycles, exp_req, guard;
        logic [1:0]  a;
        bit          al, berr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, v, mask, instr;

        a = addr[1:0];
        case (f3[1:0])
            2'b00:   nb = 1;
            2'b01:   nb = 2;
            2'b10:   nb = 4;
            default: nb = 0;
        endcase
        al = (nb != 0) && ((int'(a) % (nb == 0 ? 1 : nb)) == 0);
        exp_be = (nb == 0) ? 4'h0 : 4'(((1 << nb) - 1) << a);
        exp_wd = 32'h0;
        if (wr && nb != 0)
            for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = data[8*(i % nb) +: 8];
        v = rdata >> (8 * int'(a));
        if (nb == 1 || nb == 2) begin
            mask = (32'd1 << (8 * nb)) - 32'd1;
            v = v & mask;
            if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        end

        instr = $urandom;
        instr[14:12] = f3;
        MEMREAD_MEM  = rd;
        MEMWRITE_MEM = wr;
        ALUOUT_MEM   = addr;
        PREOP2_MEM   = data;
        INSTR_MEM    = instr;
        DMEM_ACK     = 1'($urandom_range(0, 1));
        DMEM_RDATA   = $urandom;
        if (prev_done) @(negedge clk);
        #1;
        chk("c0_stall", 32'(STALL_MEM), 32'(al));
        chk("c0_req", 32'(DMEM_REQ), 32'd0);
        chk("c0_pulses", {30'd0, MISALIGN_MEM, BUSERR_MEM}, 32'd0);

        if (!al) begin
            @(negedge clk); #1;
            chk("mis_pulse", 32'(MISALIGN_MEM), 32'd1);
            chk("mis_req", 32'(DMEM_REQ), 32'd0);
            chk("mis_buserr", 32'(BUSERR_MEM), 32'd0);
            go_idle(1);
            chk("mis_width", 32'(MISALIGN_MEM), 32'd0);
            return;
        end

        req_cycles = 0;
        guard = 0;
        while (guard < 64) begin
            @(negedge clk); #1;
            guard++;
            if (!DMEM_REQ) break;
            req_cycles++;
            chk("bus_addr", DMEM_ADDR, {addr[31:2], 2'b00});
            chk("bus_be", 32'(DMEM_BE), 32'(exp_be));
            chk("bus_we", 32'(DMEM_WE), 32'(wr));
            chk("bus_wdata", DMEM_WDATA, exp_wd);
            chk("bus_stall", 32'(STALL_MEM), 32'd1);
            if (req_cycles - 1 == waits) begin
                DMEM_ACK   = 1'b1;
                DMEM_RDATA = rdata;
            end else begin
                DMEM_ACK   = 1'b0;
                DMEM_RDATA = $urandom;
            end
        end
        chk("req_bound", 32'(DMEM_REQ), 32'd0);
        DMEM_ACK = 1'b0;

        berr    = (waits >= T);
        exp_req = berr ? T : waits + 1;
        if (!berr && !wr) ld_model = v;
        chk("req_cycles", 32'(req_cycles), 32'(exp_req));
        chk("done_stall", 32'(STALL_MEM), 32'd0);
        chk("done_buserr", 32'(BUSERR_MEM), 32'(berr));
        chk("done_mis", 32'(MISALIGN_MEM), 32'd0);
        chk("load_data", LOAD_DATA_MEM, ld_model);
        prev_done = 1'b1;
    endtask

    task automatic reset_mid_bus();
        MEMREAD_MEM  = 1'b0;
        MEMWRITE_MEM = 1'b1;
        ALUOUT_MEM   = 32'h0000_0040;
        PREOP2_MEM   = 32'h1234_5678;
        INSTR_MEM    = 32'h0000_2023;
        DMEM_ACK     = 1'b0;
        if (prev_done) @(negedge clk);
        #1;
        repeat (2) begin
            @(negedge clk); #1;
        end
        chk("rst_pre_req", 32'(DMEM_REQ), 32'd1);
        rst = 1'b1;
        MEMWRITE_MEM = 1'b0;
        @(negedge clk); #1;
        chk("rst_req", 32'(DMEM_REQ), 32'd0);
        chk("rst_stall", 32'(STALL_MEM), 32'd0);
        chk("rst_ld", LOAD_DATA_MEM, 32'd0);
        chk("rst_be", 32'(DMEM_BE), 32'd0);
        rst = 1'b0;
        ld_model  = 32'h0;
        prev_done = 1'b0;
        @(negedge clk); #1;
        chk("rst_idle_req", 32'(DMEM_REQ), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        MEMREAD_MEM = 1'b0; MEMWRITE_MEM = 1'b0;
        ALUOUT_MEM = 32'h0; PREOP2_MEM = 32'h0; INSTR_MEM = 32'h0;
        DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req0", 32'(DMEM_REQ), 32'd0);
        chk("rst_we0", 32'(DMEM_WE), 32'd0);
        chk("rst_addr0", DMEM_ADDR, 32'd0);
        chk("rst_wdata0", DMEM_WDATA, 32'd0);
        chk("rst_stall0", 32'(STALL_MEM), 32'd0);
        chk("rst_ld0", LOAD_DATA_MEM, 32'd0);
        chk("rst_pulses0", {30'd0, MISALIGN_MEM, BUSERR_MEM}, 32'd0);
        rst = 1'b0;
        go_idle(1);

        run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_value", LOAD_DATA_MEM, 32'hDEAD_BEEF);
        run_op(1, 0, 3'b000, 32'h203, 32'h0, 32'h80FF_1234, 0);
        chk("lb_value", LOAD_DATA_MEM, 32'hFFFF_FF80);
        run_op(1, 0, 3'b100, 32'h203, 32'h0, 32'h80FF_1234, 0);
        chk("lbu_value", LOAD_DATA_MEM, 32'h0000_0080);
        run_op(0, 1, 3'b001, 32'h12, 32'h0000_ABCD, 32'h0, 3);
        run_op(1, 0, 3'b001, 32'h2, 32'h0, 32'h8001_7FFF, 1);
        chk("lh_value", LOAD_DATA_MEM, 32'hFFFF_8001);
        go_idle(1);
        run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        run_op(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
        run_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        run_op(0, 1, 3'b010, 32'h200, 32'hCAFE_F00D, 32'h0, 1000);
        run_op(1, 1, 3'b010, 32'h300, 32'h0101_0202, 32'h0, T - 1);
        run_op(1, 0, 3'b110, 32'h308, 32'h0, 32'h9000_0001, T);
        reset_mid_bus();
        run_op(1, 0, 3'b010, 32'h400, 32'h0, 32'h1111_2222, 0);
        run_op(0, 1, 3'b010, 32'h404, 32'h3333_4444, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h408, 32'h0, 32'h5555_6666, 2);
        go_idle(2);

        for (int n = 0; n < 200; n++) begin
            int          kind, r, waits;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            r     = $urandom_range(0, 19);
            waits = (r == 0) ? T + 4 : r % 5;
            run_op(kind <= 4 || kind == 9, kind >= 5, f3, addr, $urandom, $urandom, waits);
            if ($urandom_range(0, 3) == 0) go_idle($urandom_range(1, 2));
        end
        go_idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
